// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmit FSM encoding and the baud divisor helper.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full and empty are derived from the occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A write while full is dropped even when a read frees a slot on the same edge.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter: queued bytes drain LSB first on a registered tx line,
// with back-to-back frames contiguous while the FIFO holds data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        data_in,
    input  logic                        data_en,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        tx,
    output logic                        busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q;
    logic                 pop, bit_done;
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (data_en),
        .wr_data(data_in),
        .rd_en  (pop),
        .rd_data(fifo_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (count)
    );

    assign bit_done = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= data_en && fifo_full;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q != IDLE) baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    // Refill straight into START so consecutive frames leave no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx and busy are registered from the current state, so they trail the FSM by one cycle.
    always_comb begin
        case (state_q)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_q[0];
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (data_en && !fifo_full) || !fifo_empty || (state_q != IDLE);
    end

    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=10, FIFO_DEPTH=4; a line monitor decodes tx frames.
module tb_uart_tx_fifo;

    localparam int CPB = 10;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_en;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       tx;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    int         rx_t_q[$];
    logic       rx_ok_q[$];

    uart_tx_fifo #(
        .CLK_FREQ  (1000000),
        .BAUD      (100000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .data_en (data_en),
        .full    (full),
        .count   (count),
        .overflow(overflow),
        .tx      (tx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        data_in = b;
        data_en = 1'b1;
        step();
        data_en = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (busy === 1'b0) break;
            step();
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t_q.delete();
        rx_ok_q.delete();
    endtask

    function automatic logic frame_level(input logic [7:0] b, input int i);
        if (i < CPB) return 1'b0;
        if (i < 9 * CPB) return b[(i - CPB) / CPB];
        return 1'b1;
    endfunction

    // Line monitor: samples each bit at its centre and records byte, start cycle and framing.
    initial begin : rx_monitor
        logic [7:0] b;
        int         t0;
        logic       ok;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                ok = ok && (tx === 1'b1);
                rx_q.push_back(b);
                rx_t_q.push_back(t0);
                rx_ok_q.push_back(ok);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t_start;
        int cyc_n;
        int lows;
        logic [7:0] exp_ovf[6];

        reset   = 1'b1;
        data_en = 1'b0;
        data_in = 8'h00;
        repeat (3) step();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        repeat (2) step();
        check("idle_tx", tx, 1);

        // Single byte 0x35: write, pop one edge later, start bit the edge after that.
        push(8'h35);
        check("t1_count_push", count, 1);
        check("t1_busy_rise", busy, 1);
        check("t1_tx_before_pop", tx, 1);
        step();
        check("t1_count_pop", count, 0);
        check("t1_tx_at_pop", tx, 1);
        step();
        t_start = cyc;
        check("t1_tx_start", tx, 0);
        for (int i = 1; i < 10 * CPB; i++) begin
            step();
            check($sformatf("t1_line_%0d", i), tx, frame_level(8'h35, i));
        end
        check("t1_busy_last_stop", busy, 1);
        step();
        check("t1_busy_fall", busy, 0);
        check("t1_tx_after", tx, 1);
        check("t1_frame_len", cyc - t_start, 10 * CPB);
        check("t1_rx_count", rx_q.size(), 1);
        check("t1_rx_byte", rx_q[0], 8'h35);
        check("t1_rx_framing", rx_ok_q[0], 1);
        check("t1_rx_start_cycle", rx_t_q[0], t_start);

        // Burst "ABC" pushed on consecutive edges.
        repeat (5) step();
        clear_rx();
        data_en = 1'b1;
        data_in = 8'h41;
        step();
        data_in = 8'h42;
        step();
        data_in = 8'h43;
        step();
        data_en = 1'b0;
        check("burst_count", count, 2);
        check("burst_tx_start", tx, 0);
        wait_idle(500, "burst_idle_timeout");
        check("burst_rx_count", rx_q.size(), 3);
        check("burst_rx_0", rx_q[0], 8'h41);
        check("burst_rx_1", rx_q[1], 8'h42);
        check("burst_rx_2", rx_q[2], 8'h43);
        check("burst_framing", rx_ok_q[0] && rx_ok_q[1] && rx_ok_q[2], 1);
        check("burst_gap_01", rx_t_q[1] - rx_t_q[0], 10 * CPB);
        check("burst_gap_12", rx_t_q[2] - rx_t_q[1], 10 * CPB);
        check("burst_total", cyc - rx_t_q[0], 30 * CPB);

        // Overflow while the first frame is in flight, then push on the pop edge.
        repeat (5) step();
        clear_rx();
        push(8'h50);
        cyc_n = cyc;
        step();
        check("ovf_count_after_pop", count, 0);
        for (int k = 0; k < 4; k++) begin
            push(8'h60 + 8'(k));
            check($sformatf("ovf_count_%0d", k + 1), count, k + 1);
            check($sformatf("ovf_full_%0d", k + 1), full, (k == 3) ? 1 : 0);
            check($sformatf("ovf_pulse_quiet_%0d", k + 1), overflow, 0);
        end
        push(8'h64);
        check("ovf_pulse", overflow, 1);
        check("ovf_count_held", count, 4);
        check("ovf_full_held", full, 1);
        step();
        check("ovf_pulse_one_cycle", overflow, 0);
        check("ovf_count_still", count, 4);

        wait_until(cyc_n + 10 * CPB);
        check("pp_full_pre", full, 1);
        check("pp_count_pre", count, 4);
        push(8'h70);
        check("pp_full_reject", overflow, 1);
        check("pp_full_count", count, 3);
        check("pp_full_flag", full, 0);

        wait_until(cyc_n + 30 * CPB);
        check("pp_two_count_pre", count, 2);
        push(8'h71);
        check("pp_two_no_overflow", overflow, 0);
        check("pp_two_count", count, 2);

        wait_idle(1000, "ovf_idle_timeout");
        exp_ovf = '{8'h50, 8'h60, 8'h61, 8'h62, 8'h63, 8'h71};
        check("ovf_rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ovf_rx_%0d", i), rx_q[i], exp_ovf[i]);
            check($sformatf("ovf_framing_%0d", i), rx_ok_q[i], 1);
        end

        // Reset during data bit 3 of 0xFF with two bytes queued.
        repeat (5) step();
        clear_rx();
        push(8'hFF);
        cyc_n = cyc;
        push(8'hAA);
        push(8'hBB);
        check("rst_mid_count_pre", count, 2);
        wait_until(cyc_n + 45);
        check("rst_mid_bit3", tx, 1);
        check("rst_mid_busy_pre", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_full", full, 0);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx !== 1'b1) lows++;
        end
        check("rst_mid_no_start", lows, 0);
        check("rst_mid_busy_after", busy, 0);
        check("rst_mid_count_after", count, 0);

        // Ten bytes in groups of three so both pointers wrap.
        clear_rx();
        for (int g = 0; g < 4; g++) begin
            data_en = 1'b1;
            for (int j = 0; j < 3 && (3 * g + j) < 10; j++) begin
                data_in = 8'(3 * g + j);
                step();
            end
            data_en = 1'b0;
            wait_idle(500, $sformatf("wrap_idle_timeout_%0d", g));
        end
        check("wrap_rx_count", rx_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("wrap_rx_%0d", i), rx_q[i], i);
            check($sformatf("wrap_framing_%0d", i), rx_ok_q[i], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
